// File: rtl/mem_arb_pkg.sv
// Shared encodings for the IF/DM memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_e;

  // Wide enough for the largest supported memory latency (15).
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between the
// instruction-fetch port and the data-memory port. Each access runs
// IDLE -> WAIT -> RESP; ties alternate so neither port starves.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  state_e           state;
  gnt_e             gnt;
  gnt_e             last_gnt;
  gnt_e             pick;
  logic [CNT_W-1:0] cnt;

  // Choose the port to serve if a grant happens this cycle; ties go to the
  // port that was not served last.
  always_comb begin
    pick = GNT_IF;
    if (if_req && dm_req) begin
      pick = (last_gnt == GNT_IF) ? GNT_DM : GNT_IF;
    end else if (dm_req) begin
      pick = GNT_DM;
    end
  end

  // Access sequencer: grant and issue the command, count down the memory
  // latency, capture read data into the granted port and pulse its ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gnt       <= GNT_IF;
      last_gnt  <= GNT_IF;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            gnt      <= pick;
            last_gnt <= pick;
            mem_en   <= 1'b1;
            cnt      <= CNT_W'(MEM_LAT);
            state    <= WAIT;
            if (pick == GNT_DM) begin
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              // Fetches never write; the write-data register keeps its value.
              mem_we   <= 1'b0;
              mem_addr <= if_addr;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= RESP;
            if (gnt == GNT_IF) begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end else begin
              // mem_we still holds the granted command's direction.
              if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
              dm_ack <= 1'b1;
            end
          end
        end
        RESP: begin
          // The ack is visible this cycle; requesters update their requests now.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, multi-cycle
// corner sequences, randomized traffic against a timestamp-based model, and a
// second instance with a one-cycle memory.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  // Instance with MEM_LAT = 2
  logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          if_ack, dm_ack, mem_en, mem_we, stall_if, stall_mem;

  // Instance with MEM_LAT = 1
  logic          b_if_req = 1'b0;
  logic [AW-1:0] b_if_addr = '0;
  logic [DW-1:0] b_if_rdata, b_dm_rdata, b_mem_wdata, b_mem_rdata;
  logic [AW-1:0] b_mem_addr;
  logic          b_if_ack, b_dm_ack, b_mem_en, b_mem_we, b_stall_if, b_stall_mem;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut_lat1 (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr('0), .dm_wdata('0),
    .dm_rdata(b_dm_rdata), .dm_ack(b_dm_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .stall_if(b_stall_if), .stall_mem(b_stall_mem)
  );

  // Memory contents as a pure function of address.
  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'h8C010004;
    return {16'hC0DE, a[15:0]};
  endfunction

  // Fixed-latency memory: data is valid only in the cycle before the edge
  // MEM_LAT cycles after the mem_en sampling edge; garbage otherwise.
  int age = 100;
  always @(posedge clk) begin
    if (mem_en) age <= 1;
    else if (age < 100) age <= age + 1;
  end
  assign mem_rdata   = (age == LAT - 1) ? mem_val(mem_addr) : 32'hBAD0BAD0;
  assign b_mem_rdata = b_mem_en ? mem_val(b_mem_addr) : 32'hBAD0BAD0;

  int n_pass  = 0;
  int n_total = 0;
  int edge_n  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic wait_ack(input bit dm, input int max, input bit chk_sif, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      tick();
      if ((dm ? dm_ack : if_ack) === 1'b1) begin
        at = edge_n;
        break;
      end
      if (chk_sif && if_ack !== 1'b1) chk("stall_if_hold", stall_if, 1);
    end
    if (at < 0) begin
      n_total++;
      $display("FAIL %s_ack_timeout: no ack within %0d cycles", dm ? "dm" : "if", max);
    end
  endtask

  typedef struct {
    bit          is_dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_if;
    logic [31:0] exp_dm;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t_dm, t_if, at, nacks, n_en, last_en, acks;
    bit order_got[4];
    vec_t v;

    vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        32'h8C010004, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'h8C010004, 32'hC0DE0100};
    vecs[2] = '{1'b1, 1'b1, 32'h40,  32'hDEADBEEF, 32'h8C010004, 32'hC0DE0100};
    vecs[3] = '{1'b0, 1'b0, 32'h24,  32'h0,        32'hC0DE0024, 32'hC0DE0100};
    vecs[4] = '{1'b1, 1'b0, 32'h3C,  32'h0,        32'hC0DE0024, 32'hC0DE003C};

    // ---- reset state ----
    #2 reset = 1'b0;
    #1 if_req = 1'b1;
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_dm_ack", dm_ack, 0);
    chk("rst_stall_if", stall_if, 1);
    chk("rst_stall_mem", stall_mem, 0);
    if_req = 1'b0;
    tick(); tick();
    chk("rst_hold_mem_en", mem_en, 0);
    reset = 1'b1;
    tick();

    // ---- tie after reset: DM first, then IF ----
    if_req = 1'b1; if_addr = 32'h20;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    tick(); t0 = edge_n;
    chk("tie_mem_en", mem_en, 1);
    chk("tie_first_addr", mem_addr, 32'h100);
    chk("tie_stall_if", stall_if, 1);
    wait_ack(1'b1, 20, 1'b1, t_dm);
    chk("tie_dm_lat", t_dm - t0, LAT);
    chk("tie_dm_rdata", dm_rdata, 32'hC0DE0100);
    chk("tie_stall_if_at_dm_ack", stall_if, 1);
    chk("tie_stall_mem_at_ack", stall_mem, 0);
    dm_req = 1'b0;
    wait_ack(1'b0, 20, 1'b0, t_if);
    chk("tie_if_after_dm", t_if - t_dm, LAT + 2);
    chk("tie_if_rdata", if_rdata, 32'hC0DE0020);
    chk("tie_if_addr", mem_addr, 32'h20);
    if_req = 1'b0;
    tick();

    // ---- both held continuously: alternating grants ----
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    nacks = 0;
    for (int i = 0; i < 40 && nacks < 4; i++) begin
      tick();
      chk("fair_single_ack", if_ack & dm_ack, 0);
      if (dm_ack === 1'b1) begin order_got[nacks] = 1'b1; nacks++; end
      else if (if_ack === 1'b1) begin order_got[nacks] = 1'b0; nacks++; end
    end
    chk("fair_count", nacks, 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("fair_order_%0d", k), order_got[k], (k % 2 == 0) ? 1 : 0);
    if_req = 1'b0; dm_req = 1'b0;
    tick();

    // ---- vector table from a fresh reset ----
    reset = 1'b0; tick(); reset = 1'b1; tick();
    for (int k = 0; k < 5; k++) begin
      v = vecs[k];
      if (v.is_dm) begin
        dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
      end else begin
        if_req = 1'b1; if_addr = v.addr;
      end
      tick(); t0 = edge_n;
      chk($sformatf("v%0d_mem_en", k), mem_en, 1);
      chk($sformatf("v%0d_mem_addr", k), mem_addr, v.addr);
      chk($sformatf("v%0d_mem_we", k), mem_we, v.we);
      if (v.we) chk($sformatf("v%0d_mem_wdata", k), mem_wdata, v.wdata);
      chk($sformatf("v%0d_stall", k), v.is_dm ? stall_mem : stall_if, 1);
      tick();
      chk($sformatf("v%0d_mem_en_drop", k), mem_en, 0);
      wait_ack(v.is_dm, 20, 1'b0, at);
      chk($sformatf("v%0d_latency", k), at - t0, LAT);
      chk($sformatf("v%0d_if_rdata", k), if_rdata, v.exp_if);
      chk($sformatf("v%0d_dm_rdata", k), dm_rdata, v.exp_dm);
      chk($sformatf("v%0d_stall_at_ack", k), v.is_dm ? stall_mem : stall_if, 0);
      chk($sformatf("v%0d_other_ack", k), v.is_dm ? if_ack : dm_ack, 0);
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      tick();
      chk($sformatf("v%0d_ack_drop", k), if_ack | dm_ack, 0);
    end

    // ---- reset asserted during WAIT ----
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    chk("midrst_mem_en", mem_en, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_mem_wdata", mem_wdata, 0);
    chk("midrst_if_rdata", if_rdata, 0);
    chk("midrst_dm_rdata", dm_rdata, 0);
    chk("midrst_if_ack", if_ack, 0);
    chk("midrst_stall_if", stall_if, 1);
    tick(); chk("midrst_no_ack_a", if_ack, 0);
    tick(); chk("midrst_no_ack_b", if_ack, 0);
    reset = 1'b1;
    tick(); t0 = edge_n;
    chk("midrst_reissue_en", mem_en, 1);
    chk("midrst_reissue_addr", mem_addr, 32'h10);
    acks = 0; at = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (if_ack === 1'b1) begin
        acks++;
        if (at < 0) at = edge_n;
        if_req = 1'b0;
      end
    end
    chk("midrst_ack_count", acks, 1);
    chk("midrst_ack_latency", at - t0, LAT);
    chk("midrst_if_rdata", if_rdata, 32'h8C010004);

    // ---- randomized traffic against a timestamp model ----
    reset = 1'b0; tick(); reset = 1'b1;
    begin
      bit          if_act = 1'b0, dm_act = 1'b0;
      bit          p_if, p_dm, p_we, e_if_ack, e_dm_ack, e_en, g, last_g, g_we;
      logic [31:0] p_if_addr, p_dm_addr, p_wdata, g_addr;
      logic [31:0] e_addr, e_if_rdata, e_dm_rdata;
      bit          e_we;
      int          free_at, ack_at, t;
      last_g = 1'b0; free_at = 0; ack_at = -1;
      e_addr = '0; e_we = 1'b0; e_if_rdata = '0; e_dm_rdata = '0;
      g = 1'b0; g_we = 1'b0; g_addr = '0;
      for (int c = 0; c < 600; c++) begin
        if (!if_act && $urandom_range(0, 2) == 0) begin
          if_act = 1'b1; if_addr = 32'($urandom_range(0, 1023)) << 2;
        end
        if (!dm_act && $urandom_range(0, 2) == 0) begin
          dm_act = 1'b1; dm_addr = 32'($urandom_range(0, 1023)) << 2;
          dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
        end
        if_req = if_act; dm_req = dm_act;
        p_if = if_req; p_dm = dm_req; p_we = dm_we;
        p_if_addr = if_addr; p_dm_addr = dm_addr; p_wdata = dm_wdata;
        tick(); t = edge_n;
        e_if_ack = 1'b0; e_dm_ack = 1'b0; e_en = 1'b0;
        if (t == ack_at) begin
          if (!g) begin e_if_ack = 1'b1; e_if_rdata = mem_val(g_addr); end
          else begin
            e_dm_ack = 1'b1;
            if (!g_we) e_dm_rdata = mem_val(g_addr);
          end
        end
        if (t >= free_at && (p_if || p_dm)) begin
          g = (p_if && p_dm) ? ~last_g : p_dm;
          last_g = g;
          g_addr = g ? p_dm_addr : p_if_addr;
          g_we = g ? p_we : 1'b0;
          e_en = 1'b1; e_addr = g_addr; e_we = g_we;
          ack_at = t + LAT; free_at = t + LAT + 2;
        end
        chk("rnd_mem_en", mem_en, e_en);
        chk("rnd_mem_addr", mem_addr, e_addr);
        chk("rnd_mem_we", mem_we, e_we);
        if (e_en && e_we) chk("rnd_mem_wdata", mem_wdata, p_wdata);
        chk("rnd_if_ack", if_ack, e_if_ack);
        chk("rnd_dm_ack", dm_ack, e_dm_ack);
        chk("rnd_if_rdata", if_rdata, e_if_rdata);
        chk("rnd_dm_rdata", dm_rdata, e_dm_rdata);
        chk("rnd_stall_if", stall_if, p_if & ~e_if_ack);
        chk("rnd_stall_mem", stall_mem, p_dm & ~e_dm_ack);
        if (e_if_ack) if_act = 1'b0;
        if (e_dm_ack) dm_act = 1'b0;
      end
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    end

    // ---- MEM_LAT = 1: back-to-back fetches ----
    b_if_req = 1'b1; b_if_addr = 32'h80;
    n_en = 0; last_en = -100;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (b_mem_en === 1'b1) begin
        if (n_en > 0) chk("lat1_en_spacing", edge_n - last_en, 3);
        chk("lat1_mem_addr", b_mem_addr, b_if_addr);
        last_en = edge_n;
        n_en++;
      end
      if (b_if_ack === 1'b1) begin
        chk("lat1_ack_latency", edge_n - last_en, 1);
        chk("lat1_if_rdata", b_if_rdata, mem_val(b_if_addr));
        b_if_addr = b_if_addr + 32'h4;
      end
    end
    chk("lat1_en_count_ge3", (n_en >= 3) ? 1 : 0, 1);
    b_if_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
